// File: rtl/jtframe_inputs_rec_pkg.sv
// Word layout and sample packing for the per-frame input recorder.
// Stored words are always active high; bits [15:12] carry the repeat count in RLE mode.
package jtframe_inputs_rec_pkg;

  localparam int WORD_W    = 16;
  localparam int DATA_W    = 12;
  localparam int COIN_LSB  = 0;
  localparam int START_LSB = 2;
  localparam int JOY_LSB   = 4;
  localparam int TEST_BIT  = 11;
  localparam int RLE_LSB   = 12;
  localparam int RLE_W     = 4;

  // Only the input bits that make it into the stored word are kept
  typedef struct packed {
    logic [1:0] coin;
    logic [1:0] start;
    logic [6:0] joy;
    logic       test;
  } sample_t;

  function automatic logic [DATA_W-1:0] pack_sample(input sample_t s);
    logic [DATA_W-1:0] w;
    w = '0;
    w[COIN_LSB  +: 2] = s.coin;
    w[START_LSB +: 2] = s.start;
    w[JOY_LSB   +: 7] = s.joy;
    w[TEST_BIT]       = s.test;
    return w;
  endfunction

endpackage

// File: rtl/jtframe_inputs_rec_fifo.sv
// Small synchronous FIFO with flush; dout shows the head word combinationally.
// A push while full is ignored unless a pop happens in the same cycle.
module jtframe_inputs_rec_fifo #(
  parameter int AW = 2,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = cnt_q[AW];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtframe_inputs_rec.sv
// Records one packed input word per frame (optionally run-length encoded) into memory
// through a small FIFO and a req/ack write port.
module jtframe_inputs_rec
  import jtframe_inputs_rec_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int AW         = 14,
  parameter int RLE        = 0,
  parameter int FIFO_AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          rec_en,
  input  logic [3:0]    game_coin,
  input  logic [3:0]    game_start,
  input  logic [9:0]    game_joy1,
  input  logic          game_test,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_din,
  output logic          mem_we,
  input  logic          mem_ok,
  output logic [AW:0]   rec_words,
  output logic          full,
  output logic          ovf
);

  logic              vs_l_q, rec_en_l_q;
  logic              tick, rise, fall, cap;
  sample_t           samp_q, samp_d;
  logic              samp_vld_q, fall_q, flush_q;
  logic [DATA_W-1:0] samp_word;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic [RLE_W-1:0]  pend_cnt_q, pend_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic              push_vld;
  logic [WORD_W-1:0] push_dat, fifo_dout;
  logic              fifo_empty, fifo_full, fifo_flush, pop;
  logic [AW-1:0]     addr_q;
  logic [AW:0]       words_q;
  logic              full_q, ovf_q;
  logic              unused_bits;

  // Upper coin/start and joystick bits are not part of the stored word
  assign unused_bits = ^{game_coin[3:2], game_start[3:2], game_joy1[9:7]};

  assign tick = vs && !vs_l_q;
  assign rise = rec_en && !rec_en_l_q;
  assign fall = !rec_en && rec_en_l_q;
  assign cap  = tick && !rise && (rec_en || (RLE != 0 && fall));

  always_comb begin
    samp_d       = '0;
    samp_d.coin  = (ACTIVE_LOW != 0) ? ~game_coin[1:0]  : game_coin[1:0];
    samp_d.start = (ACTIVE_LOW != 0) ? ~game_start[1:0] : game_start[1:0];
    samp_d.joy   = (ACTIVE_LOW != 0) ? ~game_joy1[6:0]  : game_joy1[6:0];
    samp_d.test  = game_test;
  end

  assign samp_word = pack_sample(samp_q);

  // Packer: plain one-word-per-frame, or a pending word that absorbs repeats
  always_comb begin
    push_vld   = 1'b0;
    push_dat   = '0;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    pend_vld_d = pend_vld_q;
    if (RLE == 0) begin
      push_vld = samp_vld_q;
      push_dat = {{RLE_W{1'b0}}, samp_word};
    end else if (samp_vld_q) begin
      if (pend_vld_q && samp_word == pend_q && pend_cnt_q != '1) begin
        pend_cnt_d = pend_cnt_q + RLE_W'(1);
      end else begin
        push_vld   = pend_vld_q;
        push_dat   = {pend_cnt_q, pend_q};
        pend_d     = samp_word;
        pend_cnt_d = '0;
        pend_vld_d = 1'b1;
      end
    end else if (flush_q && pend_vld_q) begin
      push_vld   = 1'b1;
      push_dat   = {pend_cnt_q, pend_q};
      pend_vld_d = 1'b0;
    end
    if (rise) begin
      push_vld   = 1'b0;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_l_q     <= 1'b0;
      rec_en_l_q <= 1'b0;
      samp_q     <= '0;
      samp_vld_q <= 1'b0;
      fall_q     <= 1'b0;
      flush_q    <= 1'b0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      vs_l_q     <= vs;
      rec_en_l_q <= rec_en;
      if (tick) samp_q <= samp_d;
      samp_vld_q <= cap;
      fall_q     <= fall;
      flush_q    <= fall_q && !rise;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  // Capacity reached keeps the FIFO drained so late words vanish without ovf
  assign fifo_flush = rise || full_q;
  assign mem_we     = !fifo_empty && !full_q;
  assign pop        = mem_we && mem_ok && !rise;

  jtframe_inputs_rec_fifo #(
    .AW (FIFO_AW),
    .DW (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (push_vld),
    .din   (push_dat),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      words_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (rise) begin
      addr_q  <= '0;
      words_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (pop) begin
        addr_q  <= addr_q + AW'(1);
        words_q <= words_q + (AW+1)'(1);
        if (&addr_q) full_q <= 1'b1;
      end
      if (push_vld && fifo_full && !pop && !full_q) ovf_q <= 1'b1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_din   = mem_we ? fifo_dout : '0;
  assign rec_words = words_q;
  assign full      = full_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_jtframe_inputs_rec.sv
// Bench for the input recorder: three instances (plain, RLE, tiny memory) share stimulus;
// writes are logged and compared per session against words derived from the frame list.
module tb_jtframe_inputs_rec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, vs, rec_en, game_test;
  logic [3:0]  game_coin, game_start;
  logic [9:0]  game_joy1;
  logic        ok0, ok1, ok2;
  logic [13:0] addr0, addr1;
  logic [2:0]  addr2;
  logic [15:0] din0, din1, din2;
  logic        we0, we1, we2;
  logic [14:0] words0, words1;
  logic [3:0]  words2;
  logic        full0, full1, full2, ovf0, ovf1, ovf2;

  int n_chk  = 0;
  int n_fail = 0;
  int ok_mode = 0;
  logic [31:0] act0[$], act1[$], act2[$];

  jtframe_inputs_rec #(.ACTIVE_LOW(1), .AW(14), .RLE(0), .FIFO_AW(2)) d0 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .rec_en(rec_en), .game_coin(game_coin),
    .game_start(game_start), .game_joy1(game_joy1), .game_test(game_test),
    .mem_addr(addr0), .mem_din(din0), .mem_we(we0), .mem_ok(ok0),
    .rec_words(words0), .full(full0), .ovf(ovf0));

  jtframe_inputs_rec #(.ACTIVE_LOW(1), .AW(14), .RLE(1), .FIFO_AW(2)) d1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .rec_en(rec_en), .game_coin(game_coin),
    .game_start(game_start), .game_joy1(game_joy1), .game_test(game_test),
    .mem_addr(addr1), .mem_din(din1), .mem_we(we1), .mem_ok(ok1),
    .rec_words(words1), .full(full1), .ovf(ovf1));

  jtframe_inputs_rec #(.ACTIVE_LOW(1), .AW(3), .RLE(0), .FIFO_AW(2)) d2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .rec_en(rec_en), .game_coin(game_coin),
    .game_start(game_start), .game_joy1(game_joy1), .game_test(game_test),
    .mem_addr(addr2), .mem_din(din2), .mem_we(we2), .mem_ok(ok2),
    .rec_words(words2), .full(full2), .ovf(ovf2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (we0 && ok0) act0.push_back({16'(addr0), din0});
      if (we1 && ok1) act1.push_back({16'(addr1), din1});
      if (we2 && ok2) act2.push_back({16'(addr2), din2});
    end
  end

  initial begin
    ok0 = 1'b0; ok1 = 1'b0; ok2 = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ok_mode)
        0: begin
          ok0 = ($urandom_range(3) != 0);
          ok1 = ($urandom_range(3) != 0);
          ok2 = ($urandom_range(3) != 0);
        end
        1: begin ok0 = 1'b1; ok1 = 1'b1; ok2 = 1'b1; end
        default: begin ok0 = 1'b0; ok1 = 1'b0; ok2 = 1'b0; end
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Active-high word straight from the documented bit layout
  function automatic logic [15:0] word_of(input logic [3:0] c, input logic [3:0] s,
                                          input logic [9:0] j, input logic t);
    logic [6:0] jl;
    logic [1:0] sl, cl;
    jl = j[6:0];
    sl = s[1:0];
    cl = c[1:0];
    return {4'h0, t, ~jl, ~sl, ~cl};
  endfunction

  task automatic pick(input int kind, input int k);
    case (kind)
      1: begin game_coin = 4'hF; game_start = 4'hF; game_joy1 = 10'h3FE; game_test = 1'b0; end
      2: begin game_coin = 4'hF; game_start = 4'hF; game_joy1 = ~10'(k + 1); game_test = 1'b0; end
      default:
        if (k == 0 || $urandom_range(9) < 4) begin
          game_coin  = 4'($urandom);
          game_start = 4'($urandom);
          game_joy1  = 10'($urandom);
          game_test  = 1'($urandom);
        end
    endcase
  endtask

  task automatic frame();
    cyc(2);
    vs = 1'b1;
    cyc(4);
    vs = 1'b0;
    cyc(10);
  endtask

  // kind: 0 random, 1 fixed 3FE/F pattern, 2 stalled memory with distinct frames,
  //       3 random with a tick on the same cycle as the rec_en rise
  task automatic session(input int n, input int kind);
    int b0, b1, b2, nl, n2, i, run;
    logic [15:0] fr[$];
    logic [15:0] e1[$];
    b0 = act0.size(); b1 = act1.size(); b2 = act2.size();
    ok_mode = (kind == 2) ? 2 : 0;
    if (kind == 3) begin
      pick(0, 0);
      cyc(2);
      vs = 1'b1; rec_en = 1'b1;
      cyc(4);
      vs = 1'b0;
      cyc(10);
    end else begin
      rec_en = 1'b1;
      cyc(3);
    end
    for (int k = 0; k < n; k++) begin
      pick(kind, k);
      frame();
      fr.push_back(word_of(game_coin, game_start, game_joy1, game_test));
    end
    if (kind == 2) begin
      cyc(2);
      chk("stall_ovf0", ovf0, 1);
      chk("stall_ovf2", ovf2, 1);
      chk("stall_ovf1", ovf1, 0);
      chk("stall_we0", we0, 1);
      chk("stall_addr0", addr0, 0);
      chk("stall_din0", din0, fr[0]);
      chk("stall_din2", din2, fr[0]);
      chk("stall_words0", words0, 0);
      ok_mode = 0;
      cyc(30);
    end
    rec_en = 1'b0;
    cyc(40);

    nl = (kind == 2 && n > 4) ? 4 : n;
    n2 = (nl > 8) ? 8 : nl;
    i = 0;
    while (i < fr.size()) begin
      run = 1;
      while (i + run < fr.size() && fr[i + run] == fr[i] && run < 16) run++;
      e1.push_back({4'(run - 1), fr[i][11:0]});
      i += run;
    end

    chk("d0_nwr", act0.size() - b0, nl);
    for (int k = 0; k < nl; k++)
      if (b0 + k < act0.size()) begin
        chk("d0_addr", 32'(act0[b0 + k][31:16]), k);
        chk("d0_din", 32'(act0[b0 + k][15:0]), 32'(fr[k]));
      end
    chk("d1_nwr", act1.size() - b1, e1.size());
    for (int k = 0; k < e1.size(); k++)
      if (b1 + k < act1.size()) begin
        chk("d1_addr", 32'(act1[b1 + k][31:16]), k);
        chk("d1_din", 32'(act1[b1 + k][15:0]), 32'(e1[k]));
      end
    chk("d2_nwr", act2.size() - b2, n2);
    for (int k = 0; k < n2; k++)
      if (b2 + k < act2.size()) begin
        chk("d2_addr", 32'(act2[b2 + k][31:16]), k);
        chk("d2_din", 32'(act2[b2 + k][15:0]), 32'(fr[k]));
      end
    chk("d0_words", words0, nl);
    chk("d0_addr_end", addr0, nl);
    chk("d1_words", words1, e1.size());
    chk("d2_words", words2, n2);
    chk("d2_full", full2, (nl >= 8) ? 1 : 0);
    chk("d2_addr_end", addr2, (nl >= 8) ? 0 : nl);
    chk("d0_full", full0, 0);
    chk("d0_ovf", ovf0, (kind == 2 && n > 4) ? 1 : 0);
    chk("d2_ovf", ovf2, (kind == 2 && n > 4) ? 1 : 0);
    chk("d1_ovf", ovf1, 0);
    chk("d0_we_idle", we0, 0);
    chk("d1_we_idle", we1, 0);
    chk("d2_we_idle", we2, 0);
  endtask

  initial begin
    rst_n = 1'b0; vs = 1'b0; rec_en = 1'b0;
    game_coin = 4'hF; game_start = 4'hF; game_joy1 = 10'h3FF; game_test = 1'b0;
    cyc(3);
    chk("rst_we0", we0, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_words0", words0, 0);
    chk("rst_full0", full0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_we1", we1, 0);
    chk("rst_words1", words1, 0);
    chk("rst_we2", we2, 0);
    chk("rst_full2", full2, 0);
    rst_n = 1'b1;
    cyc(3);

    session(3, 1);
    session(20, 1);
    session(10, 1);
    session(5, 2);
    session(6, 3);
    repeat (4) session($urandom_range(24, 1), 0);

    ok_mode = 2;
    rec_en = 1'b1;
    cyc(3);
    pick(1, 0);
    frame();
    chk("pre_rst_we0", we0, 1);
    chk("pre_rst_we2", we2, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we0", we0, 0);
    chk("arst_we2", we2, 0);
    chk("arst_din0", din0, 0);
    chk("arst_addr0", addr0, 0);
    chk("arst_words0", words0, 0);
    chk("arst_ovf0", ovf0, 0);
    chk("arst_full2", full2, 0);
    chk("arst_words1", words1, 0);
    rec_en = 1'b0;
    ok_mode = 0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
